// File: rtl/slot_pkg.sv
// Shared definitions for the spin scoring slice: FSM state encoding,
// BCD digit type, conversion length and digit-pattern helpers.
package slot_pkg;

  // Scorer FSM: wait for spin end, run the BCD conversion, score the result
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SCORE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  // One shift-add-3 step per input bit of the 10-bit spin value
  localparam int SPIN_W      = 10;
  localparam int CONV_CYCLES = SPIN_W;

  localparam bcd_t BCD_NINE = 4'd9;

  // All three digits equal (000 counts as a triple)
  function automatic logic is_triple(input bcd_t h, input bcd_t t, input bcd_t o);
    return (h == t) && (t == o);
  endfunction

  // Exactly two of the three digits equal
  function automatic logic is_pair(input bcd_t h, input bcd_t t, input bcd_t o);
    return !is_triple(h, t, o) && ((h == t) || (t == o) || (h == o));
  endfunction

endpackage

// File: rtl/spin_scorer_bin2bcd_seq.sv
// Sequential double-dabble converter: 10-bit binary to three BCD digits
// plus a thousands flag. A start pulse loads the value; one shift-add-3 step
// runs per cycle, and done pulses for one cycle after the last step. The
// digit outputs hold until the next start.
module bin2bcd_seq
  import slot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [SPIN_W-1:0] i_bin,
  output logic              o_busy,
  output logic              o_done,
  output bcd_t              o_hund,
  output bcd_t              o_tens,
  output bcd_t              o_ones,
  output logic              o_thou
);

  logic [SPIN_W-1:0] r_bin;
  logic [15:0]       r_bcd;
  logic [3:0]        r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       w_adj;

  // Add 3 to every BCD nibble that would overflow past 9 when doubled
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Load on start, then shift the binary MSB into the adjusted BCD vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_bin  <= i_bin;
        r_bcd  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_bcd <= (w_adj << 1) | {15'd0, r_bin[SPIN_W-1]};
        r_bin <= r_bin << 1;
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'(CONV_CYCLES - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_thou = |r_bcd[15:12];
  assign o_hund = r_bcd[11:8];
  assign o_tens = r_bcd[7:4];
  assign o_ones = r_bcd[3:0];

endmodule

// File: rtl/spin_scorer.sv
// Spin scorer top: detects spin start/end from the spinner's pause line,
// converts the frozen spin value to BCD, scores it and keeps the credit
// balance. Optional feature macro: PAIR_PAYOUT_EN (pairs pay PAIR_PAY).
module spin_scorer
  import slot_pkg::*;
#(
  parameter int CW          = 8,
  parameter int INIT_CREDIT = 20,
  parameter int SPIN_COST   = 1,
  parameter int JACKPOT_PAY = 50,
  parameter int PAIR_PAY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SPIN_W-1:0] spin_val,
  input  logic              pause,
  input  logic              won,
  output logic [3:0]        hund,
  output logic [3:0]        tens,
  output logic [3:0]        ones,
  output logic [CW-1:0]     credits,
  output logic              result_valid,
  output logic [CW-1:0]     payout,
  output logic              game_over,
  output logic              range_err,
  output logic              won_mismatch,
  output logic              overrun
);

  localparam logic [CW-1:0] COST    = CW'(SPIN_COST);
  localparam logic [CW-1:0] JACKPOT = CW'(JACKPOT_PAY);
`ifdef PAIR_PAYOUT_EN
  localparam logic [CW-1:0] PAIR_AMT = CW'(PAIR_PAY);
`else
  // Pairs pay nothing in this build
  localparam logic [CW-1:0] PAIR_AMT = CW'(0 * PAIR_PAY);
`endif
  localparam logic [CW+1:0] MAX_CRED = {2'b00, {CW{1'b1}}};

  state_t        r_state;
  state_t        w_nextState;
  logic          r_pauseD;
  logic          w_fall;
  logic          w_rise;
  logic          w_start;
  logic          w_fallPaid;
  logic          r_spinPaid;
  logic          r_paidLat;
  logic          r_wonLat;
  logic [CW-1:0] r_credits;
  logic [CW-1:0] r_payout;
  logic [3:0]    r_hund;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;
  logic          r_resultValid;
  logic          r_rangeErr;
  logic          r_wonMismatch;
  logic          r_overrun;

  logic          w_busy;
  logic          w_done;
  bcd_t          w_convHund;
  bcd_t          w_convTens;
  bcd_t          w_convOnes;
  logic          w_thou;

  bcd_t          w_scoreHund;
  bcd_t          w_scoreTens;
  bcd_t          w_scoreOnes;
  logic          w_triple;
  logic          w_pair;
  logic [CW-1:0] w_payout;
  logic [CW+1:0] w_creditSum;
  logic [CW-1:0] w_creditNext;

  assign w_fall     = r_pauseD & ~pause;
  assign w_rise     = ~r_pauseD & pause;
  assign w_start    = w_rise && (r_state == IDLE);
  assign w_fallPaid = w_fall && (r_credits >= COST);

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_bin   (spin_val),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_hund  (w_convHund),
    .o_tens  (w_convTens),
    .o_ones  (w_convOnes),
    .o_thou  (w_thou)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: start on spin end, leave CONV once the converter reports done
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_rise) w_nextState = CONV;
      CONV:    if (w_done && !w_busy) w_nextState = SCORE;
      SCORE:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Out-of-range values display as 999; classify the digit pattern and payout
  always_comb begin
    w_scoreHund = w_thou ? BCD_NINE : w_convHund;
    w_scoreTens = w_thou ? BCD_NINE : w_convTens;
    w_scoreOnes = w_thou ? BCD_NINE : w_convOnes;
    w_triple    = is_triple(w_scoreHund, w_scoreTens, w_scoreOnes);
    w_pair      = is_pair(w_scoreHund, w_scoreTens, w_scoreOnes);
    w_payout    = '0;
    if (r_paidLat && !w_thou) begin
      if (w_triple) begin
        w_payout = JACKPOT;
      end else if (w_pair) begin
        w_payout = PAIR_AMT;
      end
    end
  end

  // Combine spin-start deduction and score payout, saturating at the top
  always_comb begin
    w_creditSum = {2'b00, r_credits};
    if (w_fallPaid) begin
      w_creditSum = w_creditSum - {2'b00, COST};
    end
    if (r_state == SCORE) begin
      w_creditSum = w_creditSum + {2'b00, w_payout};
    end
    w_creditNext = (w_creditSum > MAX_CRED) ? {CW{1'b1}} : w_creditSum[CW-1:0];
  end

  // Pause edge history, credit balance and per-spin bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pauseD   <= 1'b1;
      r_credits  <= CW'(INIT_CREDIT);
      r_spinPaid <= 1'b0;
      r_paidLat  <= 1'b0;
      r_wonLat   <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_pauseD  <= pause;
      r_credits <= w_creditNext;
      if (w_fall) begin
        r_spinPaid <= w_fallPaid;
      end
      if (w_start) begin
        r_wonLat  <= won;
        r_paidLat <= r_spinPaid;
      end
      if (w_rise && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Publish the scored result on the SCORE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hund        <= '0;
      r_tens        <= '0;
      r_ones        <= '0;
      r_payout      <= '0;
      r_resultValid <= 1'b0;
      r_rangeErr    <= 1'b0;
      r_wonMismatch <= 1'b0;
    end else begin
      r_resultValid <= 1'b0;
      if (r_state == SCORE) begin
        r_hund        <= w_scoreHund;
        r_tens        <= w_scoreTens;
        r_ones        <= w_scoreOnes;
        r_payout      <= w_payout;
        r_resultValid <= 1'b1;
        r_rangeErr    <= w_thou;
        if (!w_thou && (r_wonLat != w_triple)) begin
          r_wonMismatch <= 1'b1;
        end
      end
    end
  end

  assign hund         = r_hund;
  assign tens         = r_tens;
  assign ones         = r_ones;
  assign credits      = r_credits;
  assign payout       = r_payout;
  assign result_valid = r_resultValid;
  assign range_err    = r_rangeErr;
  assign won_mismatch = r_wonMismatch;
  assign overrun      = r_overrun;
  assign game_over    = (r_credits < COST);

endmodule

// File: tb/tb_spin_scorer.sv
// Testbench for spin_scorer. Two instances share stimulus: dut0 uses the
// default parameters, dut1 starts with a single credit. Expected results are
// pushed per instance when a spin ends and popped when result_valid pulses.
module tb_spin_scorer;

  localparam int PAIR_EXP = `ifdef PAIR_PAYOUT_EN 2 `else 0 `endif ;
  localparam int COST_EXP = 1;
  localparam int JACK_EXP = 50;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic [7:0] pay;
    logic [7:0] cred;
    logic       re;
    logic       wm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause = 1'b1;
  logic       won = 1'b0;
  logic [9:0] spinVal = '0;

  logic [3:0] hundA[2];
  logic [3:0] tensA[2];
  logic [3:0] onesA[2];
  logic [7:0] creditsA[2];
  logic [7:0] payoutA[2];
  logic       rvA[2];
  logic       gameOverA[2];
  logic       rangeErrA[2];
  logic       wonMmA[2];
  logic       overrunA[2];
  logic [29:0] actV[2];

  int   checks = 0;
  int   errors = 0;
  int   initCred[2] = '{20, 1};
  int   mCred[2];
  logic mSpinPaid[2];
  logic mWm[2];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  spin_scorer #(.CW(8), .INIT_CREDIT(20)) dut0 (
    .clk(clk), .rst(rst), .spin_val(spinVal), .pause(pause), .won(won),
    .hund(hundA[0]), .tens(tensA[0]), .ones(onesA[0]), .credits(creditsA[0]),
    .result_valid(rvA[0]), .payout(payoutA[0]), .game_over(gameOverA[0]),
    .range_err(rangeErrA[0]), .won_mismatch(wonMmA[0]), .overrun(overrunA[0])
  );

  spin_scorer #(.CW(8), .INIT_CREDIT(1)) dut1 (
    .clk(clk), .rst(rst), .spin_val(spinVal), .pause(pause), .won(won),
    .hund(hundA[1]), .tens(tensA[1]), .ones(onesA[1]), .credits(creditsA[1]),
    .result_valid(rvA[1]), .payout(payoutA[1]), .game_over(gameOverA[1]),
    .range_err(rangeErrA[1]), .won_mismatch(wonMmA[1]), .overrun(overrunA[1])
  );

  assign actV[0] = {hundA[0], tensA[0], onesA[0], payoutA[0], creditsA[0], rangeErrA[0], wonMmA[0]};
  assign actV[1] = {hundA[1], tensA[1], onesA[1], payoutA[1], creditsA[1], rangeErrA[1], wonMmA[1]};

  // Scoreboard: every result pulse must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (rvA[i] === 1'b1) begin
          checks++;
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            errors++;
            $display("[TB] FAIL sb_unexpected_dut%0d: result_valid with no expected entry", i);
          end else begin
            if (i == 0) e = q0.pop_front();
            else e = q1.pop_front();
            if (actV[i] !== e) begin
              errors++;
              $display("[TB] FAIL sb_result_dut%0d: got h%0d t%0d o%0d pay%0d cred%0d re%0b wm%0b, expected h%0d t%0d o%0d pay%0d cred%0d re%0b wm%0b",
                       i, hundA[i], tensA[i], onesA[i], payoutA[i], creditsA[i], rangeErrA[i], wonMmA[i],
                       e.h, e.t, e.o, e.pay, e.cred, e.re, e.wm);
            end
          end
        end
      end
    end
  end

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mCred[i] = initCred[i];
      mSpinPaid[i] = 1'b0;
      mWm[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    pause = 1'b1;
    won = 1'b0;
    spinVal = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  // Model of one scored spin for both instances; overlap means a new spin
  // start lands on the same edge as the score
  task automatic modelPush(input int val, input logic w, input logic overlap);
    exp_t e;
    int   h, t, o, pay;
    logic inRange, tri3, pair, np;
    inRange = (val <= 999);
    h = inRange ? val / 100 : 9;
    t = inRange ? (val / 10) % 10 : 9;
    o = inRange ? val % 10 : 9;
    tri3 = (h == t) && (t == o);
    pair = !tri3 && ((h == t) || (t == o) || (h == o));
    for (int i = 0; i < 2; i++) begin
      pay = 0;
      if (inRange && mSpinPaid[i]) begin
        if (tri3) pay = JACK_EXP;
        else if (pair) pay = PAIR_EXP;
      end
      np = overlap && (mCred[i] >= COST_EXP);
      mCred[i] = mCred[i] - (np ? COST_EXP : 0) + pay;
      if (mCred[i] > 255) mCred[i] = 255;
      if (overlap) mSpinPaid[i] = np;
      if (inRange && (w != tri3)) mWm[i] = 1'b1;
      e.h = 4'(h);
      e.t = 4'(t);
      e.o = 4'(o);
      e.pay = 8'(pay);
      e.cred = 8'(mCred[i]);
      e.re = !inRange;
      e.wm = mWm[i];
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // Spin start: drop pause, model the deduction, check balances after the edge
  task automatic spinStart();
    @(negedge clk);
    pause = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mSpinPaid[i] = (mCred[i] >= COST_EXP);
      if (mSpinPaid[i]) mCred[i] = mCred[i] - COST_EXP;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (creditsA[i] !== 8'(mCred[i])) begin
        errors++;
        $display("[TB] FAIL start_credits_dut%0d: got %0d expected %0d", i, creditsA[i], mCred[i]);
      end
    end
  endtask

  // Spin end: raise pause, push expectations, check latency and pulse width
  task automatic spinEnd(input int val, input logic w, input logic overlap);
    int seen;
    @(negedge clk);
    spinVal = 10'(val);
    won = w;
    pause = 1'b1;
    modelPush(val, w, overlap);
    seen = 0;
    for (int k = 1; k <= 20 && seen == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (overlap && k == 12) pause = 1'b0;
      if (rvA[0] === 1'b1) seen = k;
    end
    checks++;
    if (seen !== 13) begin
      errors++;
      $display("[TB] FAIL latency_%0d: result after %0d edges, expected 13", val, seen);
    end
    @(negedge clk);
    checks++;
    if (rvA[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pulse_width_%0d: result_valid still %b, expected 0", val, rvA[0]);
    end
  endtask

  task automatic test_reset();
    int pulses;
    applyReset();
    @(negedge clk);
    checks++;
    if (creditsA[0] !== 8'd20) begin
      errors++;
      $display("[TB] FAIL reset_credits0: got %0d expected 20", creditsA[0]);
    end
    checks++;
    if (creditsA[1] !== 8'd1) begin
      errors++;
      $display("[TB] FAIL reset_credits1: got %0d expected 1", creditsA[1]);
    end
    checks++;
    if ({hundA[0], tensA[0], onesA[0]} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_digits: got %h expected 000", {hundA[0], tensA[0], onesA[0]});
    end
    checks++;
    if (payoutA[0] !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_payout: got %0d expected 0", payoutA[0]);
    end
    checks++;
    if ({gameOverA[0], rangeErrA[0], wonMmA[0], overrunA[0], rvA[0], gameOverA[1]} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {gameOverA[0], rangeErrA[0], wonMmA[0], overrunA[0], rvA[0], gameOverA[1]});
    end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rvA[0] === 1'b1 || rvA[1] === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL reset_no_result: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_jackpot();
    spinStart();
    spinEnd(777, 1'b1, 1'b0);
  endtask

  task automatic test_no_win_pair();
    spinStart();
    spinEnd(123, 1'b0, 1'b0);
    spinStart();
    spinEnd(455, 1'b0, 1'b0);
  endtask

  task automatic test_range_mismatch();
    spinStart();
    spinEnd(1010, 1'b0, 1'b0);
    spinStart();
    spinEnd(124, 1'b1, 1'b0);
    spinStart();
    spinEnd(555, 1'b1, 1'b0);
    checks++;
    if (wonMmA[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mismatch_sticky: got %b expected 1", wonMmA[0]);
    end
  endtask

  task automatic test_back_to_back();
    spinStart();
    spinEnd(222, 1'b1, 1'b1);
    spinEnd(333, 1'b1, 1'b0);
  endtask

  task automatic test_unpaid();
    applyReset();
    spinStart();
    checks++;
    if ({gameOverA[1], gameOverA[0]} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL unpaid_game_over: got %b expected 10", {gameOverA[1], gameOverA[0]});
    end
    spinEnd(123, 1'b0, 1'b0);
    spinStart();
    checks++;
    if (gameOverA[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unpaid_game_over2: got %b expected 1", gameOverA[1]);
    end
    spinEnd(111, 1'b1, 1'b0);
  endtask

  task automatic test_overrun_reset();
    int pulses;
    spinStart();
    @(negedge clk);
    spinVal = 10'd300;
    won = 1'b0;
    pause = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 2) pause = 1'b0;
      if (k == 5) begin
        checks++;
        if (overrunA[0] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL overrun_early: got %b expected 0", overrunA[0]);
        end
        pause = 1'b1;
      end
    end
    checks++;
    if ({overrunA[0], overrunA[1]} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL overrun_set: got %b expected 11", {overrunA[0], overrunA[1]});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({creditsA[0], payoutA[0], hundA[0], tensA[0], onesA[0], overrunA[0], wonMmA[0]} !== {8'd20, 8'd0, 12'h000, 2'b00}) begin
      errors++;
      $display("[TB] FAIL midconv_reset: got cred%0d pay%0d digits %h ov%b wm%b expected cred20 pay0 digits 000 ov0 wm0",
               creditsA[0], payoutA[0], {hundA[0], tensA[0], onesA[0]}, overrunA[0], wonMmA[0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rvA[0] === 1'b1 || rvA[1] === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL abandoned_result: got %0d pulses expected 0", pulses);
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_jackpot();
    test_no_win_pair();
    test_range_mismatch();
    test_back_to_back();
    test_unpaid();
    test_overrun_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (q0.size() + q1.size() !== 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover: %0d entries never matched, expected 0", q0.size() + q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
